// File: rtl/player_plotter.sv
// -----------------------------------------------------------------------------
// player_plotter
//
// Scans the player's rectangular sprite one pixel per clock. It starts at the
// latched top-left corner and drives the VGA adapter's pixel write interface.
// A start/busy/done handshake lets the game FSM sequence erase-then-draw.
// Pixels that fall off the right or bottom edge of the screen are clipped:
// they are not written, but they still take their scan cycle. A scan
// therefore always lasts WIDTH*HEIGHT cycles.
//
// Ports:
//   clock       main clock
//   reset       asynchronous, active-high reset
//   start       one-cycle plot request, honoured only while idle
//   x_in        sprite top-left x (latched on start)
//   y_in        sprite top-left y (latched on start)
//   colour_in   sprite colour (latched on start; 000 erases)
//   vga_x       pixel x to the VGA adapter
//   vga_y       pixel y to the VGA adapter
//   vga_colour  pixel colour to the VGA adapter
//   plot        VGA write enable (pixel is on screen)
//   busy        high while the sprite is being scanned
//   done        one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module player_plotter #(
    parameter int WIDTH    = 12,
    parameter int HEIGHT   = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    localparam logic [4:0] CX_LAST = 5'(WIDTH - 1);
    localparam logic [4:0] CY_LAST = 5'(HEIGHT - 1);
    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

    state_t     state_q, state_d;
    logic [7:0] bx_q, bx_d;
    logic [6:0] by_q, by_d;
    logic [2:0] bc_q, bc_d;
    logic [4:0] cx_q, cx_d;
    logic [4:0] cy_q, cy_d;

    logic [7:0] vga_x_d;
    logic [6:0] vga_y_d;
    logic [2:0] vga_colour_d;
    logic       plot_d, busy_d, done_d;

    // The sums are one bit wider than the screen coordinates. A sprite that
    // extends past 255/127 must be clipped rather than wrap back on screen.
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    assign sum_x = {1'b0, bx_q} + {4'b0, cx_q};
    assign sum_y = {1'b0, by_q} + {3'b0, cy_q};

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the edge, which keeps
    // simulation and synthesis in agreement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output is registered. The value presented after an edge is the
    // action of the state that was current at that edge. That gives one
    // cycle of latency from start to the first pixel, and puts done one
    // cycle after the last pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bx_q       <= '0;
            by_q       <= '0;
            bc_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            bx_q       <= bx_d;
            by_q       <= by_d;
            bc_q       <= bc_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            vga_x      <= vga_x_d;
            vga_y      <= vga_y_d;
            vga_colour <= vga_colour_d;
            plot       <= plot_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // NOTE: every signal assigned here gets a default first. No path can then
    // leave a value unassigned, so no latches are inferred.
    always_comb begin
        state_d      = state_q;
        bx_d         = bx_q;
        by_d         = by_q;
        bc_d         = bc_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        vga_x_d      = vga_x;
        vga_y_d      = vga_y;
        vga_colour_d = vga_colour;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bx_d    = x_in;
                    by_d    = y_in;
                    bc_d    = colour_in;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                vga_x_d      = sum_x[7:0];
                vga_y_d      = sum_y[6:0];
                vga_colour_d = bc_q;
                busy_d       = 1'b1;
                plot_d       = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
                // Row-major walk. Clipped pixels still advance the counters.
                if (cx_q == CX_LAST) begin
                    cx_d = '0;
                    if (cy_q == CY_LAST) begin
                        state_d = FINISH;
                    end else begin
                        cy_d = cy_q + 5'd1;
                    end
                end else begin
                    cx_d = cx_q + 5'd1;
                end
            end

            FINISH: begin
                // vga_x/y/colour keep the last pixel through the done pulse.
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_player_plotter.sv
module tb_player_plotter;

    localparam int W      = 12;
    localparam int H      = 8;
    localparam int PIXELS = W * H;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, busy, done;

    // 1x1 sprite instance for the degenerate-size case
    logic       start_s;
    logic [7:0] vga_x_s;
    logic [6:0] vga_y_s;
    logic [2:0] vga_colour_s;
    logic       plot_s, busy_s, done_s;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    player_plotter dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    player_plotter #(.WIDTH(1), .HEIGHT(1)) dut_small (
        .clock      (clock),
        .reset      (reset),
        .start      (start_s),
        .x_in       (8'd0),
        .y_in       (7'd0),
        .colour_in  (3'b111),
        .vga_x      (vga_x_s),
        .vga_y      (vga_y_s),
        .vga_colour (vga_colour_s),
        .plot       (plot_s),
        .busy       (busy_s),
        .done       (done_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packed view of everything the plotter drives: {x, y, colour, plot, busy, done}
    function automatic logic [20:0] outs();
        return {vga_x, vga_y, vga_colour, plot, busy, done};
    endfunction

    // Reference: the k-th scanned pixel of a W x H sprite at (bx, by).
    // Scan order is row-major. A pixel is written when it is on a 160x120
    // screen. The VGA coordinates carry the low bits of the true sum.
    function automatic logic [20:0] model_pixel(input int bx, input int by,
                                                input logic [2:0] c, input int k);
        int  sx, sy;
        logic on;
        sx = bx + (k % W);
        sy = by + (k / W);
        on = (sx < 160) && (sy < 120);
        return {8'(sx), 7'(sy), c, on, 1'b1, 1'b0};
    endfunction

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         plots;
        logic [7:0] fx;
        logic [6:0] fy;
        logic [7:0] lx;
        logic [6:0] ly;
    } vec_t;

    // Count of written pixels plus first/last written coordinate of the last scan
    int         n_plots;
    logic [7:0] first_x, last_x;
    logic [6:0] first_y, last_y;

    // One full scan from idle. Inputs are scrambled after start is taken,
    // and the scrambled values must have no effect on the scan.
    task automatic run_scan(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                            input string tag);
        logic [20:0] exp;
        n_plots = 0;
        @(negedge clock);
        x_in = x; y_in = y; colour_in = c; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 0; k < PIXELS; k++) begin
            @(posedge clock);
            #1;
            exp = model_pixel(int'(x), int'(y), c, k);
            check({tag, " pixel"}, 32'(outs()), 32'(exp));
            if (plot) begin
                if (n_plots == 0) begin
                    first_x = vga_x; first_y = vga_y;
                end
                last_x = vga_x; last_y = vga_y;
                n_plots++;
            end
            x_in      = 8'($urandom);
            y_in      = 7'($urandom);
            colour_in = 3'($urandom);
        end
        @(posedge clock);
        #1;
        exp = model_pixel(int'(x), int'(y), c, PIXELS - 1);
        check({tag, " finish"}, 32'(outs()), 32'({exp[20:3], 3'b001}));
        @(posedge clock);
        #1;
        check({tag, " idle"}, 32'({plot, busy, done}), 32'(3'b000));
    endtask

    // Wait for a done pulse within a cycle budget; an expired budget is a failure
    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, " done seen"}, 32'(done), 32'(1));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'd14,  7'd99,  3'b111, 96, 8'd14,  7'd99,  8'd25,  7'd106};
        vecs[1] = '{8'd134, 7'd99,  3'b000, 96, 8'd134, 7'd99,  8'd145, 7'd106};
        vecs[2] = '{8'd155, 7'd115, 3'b011, 25, 8'd155, 7'd115, 8'd159, 7'd119};
        vecs[3] = '{8'd149, 7'd118, 3'b101, 22, 8'd149, 7'd118, 8'd159, 7'd119};
        vecs[4] = '{8'd148, 7'd112, 3'b110, 96, 8'd148, 7'd112, 8'd159, 7'd119};
        vecs[5] = '{8'd250, 7'd50,  3'b010, 0,  8'd0,   7'd0,   8'd0,   7'd0};

        reset = 1'b1; start = 1'b0; start_s = 1'b0;
        x_in = '0; y_in = '0; colour_in = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset outputs", 32'(outs()), 32'(0));
        check("reset small", 32'({vga_x_s, vga_y_s, vga_colour_s, plot_s, busy_s, done_s}), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle no start", 32'({plot, busy, done}), 32'(0));

        // Table-driven scans, including erase and clipping at both edges
        foreach (vecs[i]) begin
            run_scan(vecs[i].x, vecs[i].y, vecs[i].c, $sformatf("vec%0d", i));
            check($sformatf("vec%0d plot count", i), 32'(n_plots), 32'(vecs[i].plots));
            if (vecs[i].plots > 0) begin
                check($sformatf("vec%0d first", i), 32'({first_x, first_y}),
                      32'({vecs[i].fx, vecs[i].fy}));
                check($sformatf("vec%0d last", i), 32'({last_x, last_y}),
                      32'({vecs[i].lx, vecs[i].ly}));
            end
        end

        // Randomised scans against the reference model
        for (int r = 0; r < 8; r++) begin
            run_scan(8'($urandom), 7'($urandom), 3'($urandom), $sformatf("rnd%0d", r));
        end

        // start held high; x_in changes mid-scan; a second scan starts only
        // after the FINISH cycle returns to idle
        @(negedge clock);
        x_in = 8'd30; y_in = 7'd10; colour_in = 3'b101; start = 1'b1;
        @(posedge clock);
        for (int k = 0; k < PIXELS; k++) begin
            @(posedge clock);
            #1;
            check("held pixel", 32'(outs()), 32'(model_pixel(30, 10, 3'b101, k)));
            if (k == 10) x_in = 8'd54;
        end
        @(posedge clock);
        #1;
        check("held finish", 32'({plot, busy, done}), 32'(3'b001));
        @(posedge clock);
        #1;
        check("held idle gap", 32'({plot, busy, done}), 32'(3'b000));
        @(posedge clock);
        #1;
        check("held rescan", 32'(outs()), 32'(model_pixel(54, 10, 3'b101, 0)));
        start = 1'b0;
        wait_done(PIXELS + 4, "held rescan");
        @(posedge clock);
        #1;

        // Reset in the middle of a scan
        @(negedge clock);
        x_in = 8'd40; y_in = 7'd20; colour_in = 3'b111; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("pre-reset pixel", 32'(outs()), 32'(model_pixel(40, 20, 3'b111, 39)));
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async reset", 32'(outs()), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check("no done after reset", 32'({plot, busy, done}), 32'(0));
        end
        run_scan(8'd40, 7'd20, 3'b111, "post-reset");
        check("post-reset plot count", 32'(n_plots), 32'(96));

        // 1x1 sprite: one pixel, then done
        @(negedge clock);
        start_s = 1'b1;
        @(posedge clock);
        #1;
        start_s = 1'b0;
        check("small latency", 32'({plot_s, busy_s}), 32'(2'b00));
        @(posedge clock);
        #1;
        check("small pixel", 32'({vga_x_s, vga_y_s, vga_colour_s, plot_s, busy_s, done_s}),
              32'({8'd0, 7'd0, 3'b111, 3'b110}));
        @(posedge clock);
        #1;
        check("small done", 32'({plot_s, busy_s, done_s}), 32'(3'b001));
        @(posedge clock);
        #1;
        check("small idle", 32'({plot_s, busy_s, done_s}), 32'(3'b000));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
